// File: rtl/sar_search_ctrl_if.sv
// Start/compare/result bundle between a SAR search controller (master) and its
// requester plus external magnitude comparator (slave).
interface sar_search_ctrl_if #(
   parameter int WIDTH = 4
);
   localparam int SW = $clog2(WIDTH + 1);

   logic             start;
   logic             cmp_gt;
   logic             cmp_eq;
   logic             cmp_lt;
   logic [WIDTH-1:0] trial;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [SW-1:0]    steps;
   logic             err;

   modport master (
      input  start, cmp_gt, cmp_eq, cmp_lt,
      output trial, busy, done, result, steps, err
   );

   modport slave (
      output start, cmp_gt, cmp_eq, cmp_lt,
      input  trial, busy, done, result, steps, err
   );
endinterface

// File: rtl/sar_search_ctrl.sv
// Binary-search controller recovering a hidden operand A through a compare-only port.
// Optional define SAR_ERR_CHK_EN aborts a search when the comparator flags are not one-hot.
//
// state  | meaning
// IDLE   | trial=0, waiting for start
// SEARCH | one compare per cycle, bit k under test
module sar_search_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   sar_search_ctrl_if.master  bus
);
   localparam int SW = $clog2(WIDTH + 1);
   localparam int KW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MSB_W = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [KW-1:0]    K_MSB = KW'(WIDTH - 1);
   localparam logic [KW-1:0]    ONE_K = {{(KW-1){1'b0}}, 1'b1};
   localparam logic [SW-1:0]    ONE_S = {{(SW-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, SEARCH} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] trial_q;
   logic [WIDTH-1:0] result_q;
   logic [KW-1:0]    k_q;
   logic [SW-1:0]    cnt_q;
   logic [SW-1:0]    steps_q;
   logic             busy_q;
   logic             done_q;
`ifdef SAR_ERR_CHK_EN
   logic             err_q;
   logic             fin_err;
`endif

   logic [WIDTH-1:0] mask_k;
   logic [WIDTH-1:0] mask_km1;
   logic [WIDTH-1:0] trial_keep;
   logic [WIDTH-1:0] trial_clr;
   logic [WIDTH-1:0] trial_nx;
   logic [WIDTH-1:0] fin_result;
   logic [SW-1:0]    cnt_inc;
   logic             last_bit;
   logic             fin;

   // At k==0 mask_km1 is zero, so trial_clr is simply the trial with bit 0 cleared.
   always_comb begin
      mask_k     = ONE_W << k_q;
      mask_km1   = mask_k >> 1;
      trial_keep = trial_q | mask_km1;
      trial_clr  = (trial_q & ~mask_k) | mask_km1;
      cnt_inc    = cnt_q + ONE_S;
      last_bit   = (k_q == '0);
      fin        = 1'b0;
      fin_result = trial_q;
      trial_nx   = trial_q;
      if (bus.cmp_eq) begin
         fin = 1'b1;
      end else if (bus.cmp_gt) begin
         if (last_bit) fin = 1'b1;
         else          trial_nx = trial_keep;
      end else begin
         if (last_bit) begin
            fin        = 1'b1;
            fin_result = trial_clr;
         end else begin
            trial_nx = trial_clr;
         end
      end
`ifdef SAR_ERR_CHK_EN
      fin_err = !$onehot({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt});
      if (fin_err) begin
         fin        = 1'b1;
         fin_result = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         trial_q  <= '0;
         result_q <= '0;
         k_q      <= '0;
         cnt_q    <= '0;
         steps_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SAR_ERR_CHK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            if (bus.start) begin
               state_q <= SEARCH;
               trial_q <= MSB_W;
               k_q     <= K_MSB;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
`ifdef SAR_ERR_CHK_EN
               err_q   <= 1'b0;
`endif
            end
         end else begin
            cnt_q <= cnt_inc;
            if (fin) begin
               state_q  <= IDLE;
               trial_q  <= '0;
               result_q <= fin_result;
               steps_q  <= cnt_inc;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
`ifdef SAR_ERR_CHK_EN
               err_q    <= fin_err;
`endif
            end else begin
               trial_q <= trial_nx;
               k_q     <= k_q - ONE_K;
            end
         end
      end
   end

   assign bus.trial  = trial_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.steps  = steps_q;
`ifdef SAR_ERR_CHK_EN
   assign bus.err    = err_q;
`else
   assign bus.err    = 1'b0;
`endif
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Scoreboard bench for sar_search_ctrl: a comparator model answers trials for a chosen A,
// expected outcomes are queued at start acceptance and checked by an independent monitor.
module tb_sar_search_ctrl;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sar_search_ctrl_if #(.WIDTH(W)) bus ();
   sar_search_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      int a;
      int res;
      int steps;
      int err;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int errors = 0;
   int a_val = 0;
   int force_step = 0;
   int cur_step = 0;

   // Ideal comparator; a forced step presents the illegal gt+eq pair.
   always_comb begin
      bus.cmp_gt = (a_val > int'(bus.trial));
      bus.cmp_eq = (a_val == int'(bus.trial));
      bus.cmp_lt = (a_val < int'(bus.trial));
      if (bus.busy && force_step != 0 && cur_step == force_step) begin
         bus.cmp_gt = 1'b1;
         bus.cmp_eq = 1'b1;
         bus.cmp_lt = 1'b0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      cur_step <= 0;
      else if (!bus.busy && bus.start) cur_step <= 1;
      else if (bus.busy)               cur_step <= cur_step + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Trial j (1-based) holds A's top j-1 bits followed by a single probe bit.
   function automatic int exp_trial(input int a, input int j);
      int lowmask;
      lowmask = (1 << (W - j + 1)) - 1;
      return (a & ~lowmask) | (1 << (W - j));
   endfunction

   // Equality is first hit at the step that probes A's lowest set bit.
   function automatic int nat_steps(input int a);
      if (a == 0) return W;
      for (int b = 0; b < W; b++)
         if (((a >> b) & 1) == 1) return W - b;
      return W;
   endfunction

   function automatic exp_t model(input int a, input int fs);
      exp_t e;
      int   ns;
      ns = nat_steps(a);
      e.a = a;
      if (fs != 0 && fs <= ns) begin
         e.steps = fs;
`ifdef SAR_ERR_CHK_EN
         e.res = 0;
         e.err = 1;
`else
         e.res = exp_trial(a, fs);
         e.err = 0;
`endif
      end else begin
         e.res   = a;
         e.steps = ns;
         e.err   = 0;
      end
      return e;
   endfunction

   initial begin : monitor
      int   busy_cnt;
      exp_t e;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_cnt = 0;
         end else begin
            if (bus.busy) begin
               busy_cnt++;
               if (sbq.size() > 0 && busy_cnt <= W)
                  chk("trial", int'(bus.trial), exp_trial(sbq[0].a, busy_cnt));
            end
            if (bus.done) begin
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
               end else begin
                  e = sbq.pop_front();
                  chk("result", int'(bus.result), e.res);
                  chk("steps", int'(bus.steps), e.steps);
                  chk("err", int'(bus.err), e.err);
                  chk("latency", busy_cnt, e.steps);
                  chk("busy_at_done", int'(bus.busy), 0);
               end
               busy_cnt = 0;
            end
         end
      end
   end

   task automatic issue(input int a, input int fs, input bit push);
      a_val      = a;
      force_step = fs;
      bus.start  = 1'b1;
      @(posedge clk);
      if (push) sbq.push_back(model(a, fs));
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_done();
      for (int n = 0; n < 4 * W; n++) begin
         @(negedge clk);
         if (bus.done) return;
      end
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 required=1 t=%0t", $time);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_trial"}, int'(bus.trial), 0);
      chk({tag, "_busy"}, int'(bus.busy), 0);
      chk({tag, "_done"}, int'(bus.done), 0);
      chk({tag, "_result"}, int'(bus.result), 0);
      chk({tag, "_steps"}, int'(bus.steps), 0);
      chk({tag, "_err"}, int'(bus.err), 0);
   endtask

   initial begin : stim
      int a;
      int fs;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;

      // directed: A=5, A=8, A=0, A=15 with an idle gap between them
      issue(5, 0, 1'b1); wait_done(); @(negedge clk);
      issue(8, 0, 1'b1); wait_done(); @(negedge clk);
      issue(0, 0, 1'b1); wait_done(); @(negedge clk);
      issue(15, 0, 1'b1); wait_done();

      // back-to-back sweep, start reasserted in each done cycle; odd A gets a start while busy
      for (int i = 0; i < (1 << W); i++) begin
         issue(i, 0, 1'b1);
         if ((i % 2) == 1) begin
            @(negedge clk) bus.start = 1'b1;
            @(negedge clk) bus.start = 1'b0;
         end
         wait_done();
      end
      @(negedge clk);
      chk("idle_after_ignored_start", int'(bus.busy), 0);

      // reset in the 2nd search cycle
      issue(6, 0, 1'b0);
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midreset");
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      issue(6, 0, 1'b1); wait_done(); @(negedge clk);

      // illegal gt+eq on the 2nd compare, then a clean search
      issue(3, 2, 1'b1); wait_done();
      issue(9, 0, 1'b1); wait_done();

      // randomized searches, some with an illegal flag cycle
      repeat (40) begin
         a  = $urandom_range(0, (1 << W) - 1);
         fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W) : 0;
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         issue(a, fs, 1'b1);
         wait_done();
      end

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
